jt51_cpu_wr: RTL
================

// Module: jt51_cpu_wr
// PURPOSE
// Host-side initiator for the jt51 CPU port (cs_n/wr_n/a0/din/dout).
// Buffers (register, value) write requests in a FIFO and replays each one as the
// two-phase bus sequence: poll busy, address write (a0=0), then data write (a0=1).
// Sits between a sequencer/CPU/VGM player and jt51, so callers never see busy timing.
// PARAMETERS
// DEPTH     8     FIFO entries (power of 2, >=2)
// WR_HOLD   4     clk cycles wr_n/cs_n held low per write phase (>= 2 cen_p1 periods)
// GAP       2     clk cycles bus released between address and data phases
// SETTLE    8     clk cycles after data phase before polling busy again
// BUSY_TMO  1024  max clk cycles spent polling busy before forcing the write
// PORTS
// clk          in   1   main clock
// rst          in   1   asynchronous reset, active high
// req_valid    in   1   write request present
// req_ready    out  1   FIFO can accept request (= !full, registered)
// req_addr     in   8   jt51 register address
// req_data     in   8   value to write
// cs_n         out  1   to jt51 cs_n
// wr_n         out  1   to jt51 wr_n
// a0           out  1   to jt51 a0
// bus_dout     out  8   to jt51 din
// bus_din      in   8   from jt51 dout; bit7 = busy, bit1 = flag_B, bit0 = flag_A
// err_clr      in   1   clears timeout_err
// idle         out  1   FIFO empty and FSM in IDLE
// timeout_err  out  1   sticky: a busy poll hit BUSY_TMO
// level        out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
// - Reset (async): cs_n=1, wr_n=1, a0=0, bus_dout=0, req_ready=1, idle=1,
//   timeout_err=0, level=0. The FIFO is emptied and the FSM goes to IDLE.
// - Reset mid-transaction releases the bus immediately and drops the entry.
// - All bus outputs are registered, so there are no glitches on cs_n/wr_n.
// - FIFO: push on req_valid&&req_ready, storing {addr,data}. Pop only in IDLE.
//   - Push while full is ignored.
//   - Push and pop in the same cycle leave level unchanged.
//   - req_ready is recomputed from the next level each cycle.
// - FSM states and bus values:
//   - IDLE: bus released (cs_n=1, wr_n=1). If FIFO non-empty, pop head into
//     addr_r/data_r and go to POLL.
//   - POLL: cs_n=0, wr_n=1 (status read).
//     - bus_din is registered and evaluated from the second POLL cycle on.
//     - busy==0 -> ADDR.
//     - Poll counter reaching BUSY_TMO -> set timeout_err, go to ADDR anyway.
//   - ADDR: cs_n=0, wr_n=0, a0=0, bus_dout=addr_r for WR_HOLD cycles -> GAP1.
//   - GAP1: cs_n=1, wr_n=1, a0=0 held, bus_dout held, for GAP cycles -> DATA.
//   - DATA: cs_n=0, wr_n=0, a0=1, bus_dout=data_r for WR_HOLD cycles -> SETTLE.
//   - SETTLE: bus released, a0 returns to 0, for SETTLE cycles -> IDLE.
// - Latency: request pushed at edge N -> popped at N+1 -> cs_n low after edge N+2.
// - With busy=0, one write is IDLE 1 + POLL 2 + WR_HOLD + GAP + WR_HOLD + SETTLE
//   cycles. Defaults give 21 cycles.
// - timeout_err and err_clr: set has priority over a simultaneous err_clr.
// - idle=1 iff state==IDLE and level==0, registered.
// - Counters saturate/reload per state and never wrap inside a phase.
//   Width is $clog2(max(BUSY_TMO, WR_HOLD, GAP, SETTLE)+1).
// TESTING
// - Single write 0x20<-0xC7 with busy=0: cs_n/wr_n low WR_HOLD=4 cycles with
//   a0=0, bus_dout=0x20. After GAP=2, 4 cycles with a0=1, bus_dout=0xC7.
//   idle returns 1 after 21 cycles.
// - busy held 1 for 50 cycles after the first write, second request queued:
//   the second ADDR phase starts no earlier than the cycle after busy falls.
//   timeout_err stays 0.
// - busy stuck 1: timeout_err=1 after 1024 POLL cycles and the write proceeds.
//   Pulse err_clr coincident with a new timeout: flag stays 1.
// - Push 9 requests back-to-back with DEPTH=8 while the bus stalls on busy:
//   req_ready=0 at level 8, the 9th is held off, all 8 are written in order.
// - Push exactly as a pop occurs: level is unchanged and no entry is lost or
//   duplicated. Verify by a scoreboard of addr/data pairs.
// - Assert rst during the DATA phase: cs_n=wr_n=1 and a0=0 in the same cycle,
//   level=0. After release, a new request executes normally.

Source files
------------

// File: rtl/jt51_cpu_wr_if.sv
// jt51_cpu_wr_if
// Groups the request handshake and the jt51 CPU-bus signals of the
// jt51_cpu_wr write initiator.
//   req_valid/req_ready/req_addr/req_data : write-request handshake (host side)
//   cs_n/wr_n/a0/bus_dout                 : driven towards jt51 (cs_n, wr_n, a0, din)
//   bus_din                               : jt51 dout; bit7 busy, bit1 flag_B, bit0 flag_A
// Modports:
//   slave  : the write initiator (accepts requests, drives the jt51 bus)
//   master : the requester / bus model side (testbench, sequencer + jt51)
interface jt51_cpu_wr_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_addr;
    logic [7:0] req_data;
    logic       cs_n;
    logic       wr_n;
    logic       a0;
    logic [7:0] bus_dout;
    logic [7:0] bus_din;

    modport slave (
        input  req_valid, req_addr, req_data, bus_din,
        output req_ready, cs_n, wr_n, a0, bus_dout
    );

    modport master (
        output req_valid, req_addr, req_data, bus_din,
        input  req_ready, cs_n, wr_n, a0, bus_dout
    );
endinterface

// File: rtl/jt51_cpu_wr.sv
// jt51_cpu_wr
// Host-side write initiator for the jt51 CPU port. (register, value) pairs are
// buffered in a FIFO and replayed as: poll busy, address write (a0=0), gap,
// data write (a0=1), settle. Callers never see jt51 busy timing.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   io (slave)   : request handshake + jt51 bus (see jt51_cpu_wr_if)
//   err_clr      : clears the sticky timeout flag (a new timeout wins)
//   idle         : registered, FIFO empty and FSM idle
//   timeout_err  : sticky, a busy poll ran into BUSY_TMO
//   level        : FIFO occupancy, 0..DEPTH
module jt51_cpu_wr #(
    parameter int DEPTH    = 8,
    parameter int WR_HOLD  = 4,
    parameter int GAP      = 2,
    parameter int SETTLE   = 8,
    parameter int BUSY_TMO = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    jt51_cpu_wr_if.slave             io,
    input  logic                     err_clr,
    output logic                     idle,
    output logic                     timeout_err,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int M1   = (WR_HOLD > GAP) ? WR_HOLD : GAP;
    localparam int M2   = (M1 > SETTLE) ? M1 : SETTLE;
    localparam int MAXC = (M2 > BUSY_TMO) ? M2 : BUSY_TMO;
    localparam int CW   = $clog2(MAXC + 1);

    // Last count value of each timed phase
    localparam logic [CW-1:0] C_HOLD   = CW'(WR_HOLD - 1);
    localparam logic [CW-1:0] C_GAP    = CW'(GAP - 1);
    localparam logic [CW-1:0] C_SETTLE = CW'(SETTLE - 1);
    localparam logic [CW-1:0] C_TMO    = CW'(BUSY_TMO - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_POLL   = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_GAP1   = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_SETTLE = 3'd5;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          ready_q, ready_d;
    logic          push, pop;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    addr_q, data_q;
    logic          busy_q;
    logic          err_q, err_d;
    logic          tmo_set;
    logic          idle_q, idle_d;

    logic          cs_n_q, cs_n_d;
    logic          wr_n_q, wr_n_d;
    logic          a0_q, a0_d;
    logic [7:0]    dout_q, dout_d;

    // Only the busy bit matters here; the timer flags are not consumed.
    logic          unused_status;
    assign unused_status = ^io.bus_din[6:0];

    // req_ready is registered, so a full FIFO never accepts a push.
    assign push    = io.req_valid && ready_q;
    // Entries leave the FIFO only while the FSM sits in IDLE.
    assign pop     = (state_q == S_IDLE) && (level_q != '0);
    assign level_d = level_q + LW'(push) - LW'(pop);
    assign ready_d = (level_d != LW'(DEPTH));

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {io.req_addr, io.req_data};
    end

    // ------------------------------------------------------------------
    // Sequencer. One counter serves every timed state; it reloads to 0 on
    // each state change and stops at the phase's last value, so it cannot
    // wrap inside a phase.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (pop) state_d = S_POLL;
            end
            S_POLL: begin
                // busy_q holds the status sampled during the previous POLL
                // cycle, so it is trusted only from the second cycle on.
                if (cnt_q != '0 && !busy_q) begin
                    state_d = S_ADDR;
                    cnt_d   = '0;
                end else if (cnt_q == C_TMO) begin
                    // Give up waiting; the write is forced through.
                    state_d = S_ADDR;
                    cnt_d   = '0;
                    tmo_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ADDR: begin
                if (cnt_q == C_HOLD) begin
                    state_d = S_GAP1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP1: begin
                if (cnt_q == C_GAP) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == C_HOLD) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == C_SETTLE) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A timeout in the same cycle as err_clr keeps the flag set.
    assign err_d  = tmo_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    assign idle_d = (state_d == S_IDLE) && (level_d == '0);

    // ------------------------------------------------------------------
    // Bus outputs are a registered image of the current state, so every
    // bus phase trails its state by one clock and lasts exactly as long.
    // ------------------------------------------------------------------
    always_comb begin
        cs_n_d = 1'b1;
        wr_n_d = 1'b1;
        a0_d   = a0_q;
        dout_d = dout_q;
        case (state_q)
            S_POLL: begin
                cs_n_d = 1'b0;
                a0_d   = 1'b0;
            end
            S_ADDR: begin
                cs_n_d = 1'b0;
                wr_n_d = 1'b0;
                a0_d   = 1'b0;
                dout_d = addr_q;
            end
            S_GAP1: begin
                // a0 and bus_dout keep the address-phase values
            end
            S_DATA: begin
                cs_n_d = 1'b0;
                wr_n_d = 1'b0;
                a0_d   = 1'b1;
                dout_d = data_q;
            end
            default: begin
                a0_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
            idle_q   <= 1'b1;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            cs_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            a0_q     <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            ready_q <= ready_d;
            idle_q  <= idle_d;
            err_q   <= err_d;
            busy_q  <= io.bus_din[7];
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                addr_q   <= mem_q[rd_ptr_q][15:8];
                data_q   <= mem_q[rd_ptr_q][7:0];
            end
            cs_n_q <= cs_n_d;
            wr_n_q <= wr_n_d;
            a0_q   <= a0_d;
            dout_q <= dout_d;
        end
    end

    assign io.req_ready = ready_q;
    assign io.cs_n      = cs_n_q;
    assign io.wr_n      = wr_n_q;
    assign io.a0        = a0_q;
    assign io.bus_dout  = dout_q;
    assign idle         = idle_q;
    assign timeout_err  = err_q;
    assign level        = level_q;
endmodule
